// File: rtl/apb_xfer_scheduler_pkg.sv
// Shared types and bus widths for the APB transfer scheduler.
package apb_xfer_scheduler_pkg;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int APB_SW = 4;

    // Transfer sequencing: one idle/arbitration phase, then the two APB phases.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } xfer_state_t;

endpackage

// File: rtl/apb_xfer_scheduler_if.sv
// APB bus bundle between the scheduler (master side) and the slave fabric.
interface apb_xfer_scheduler_if #(
    parameter int NSLV = 4
);
    import apb_xfer_scheduler_pkg::*;

    logic [NSLV-1:0]   psel;
    logic              penable;
    logic [APB_AW-1:0] paddr;
    logic              pwrite;
    logic [APB_DW-1:0] pwdata;
    logic [APB_SW-1:0] pstrb;
    logic [2:0]        pprot;
    logic [APB_DW-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_xfer_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first valid requester strictly after 'last', wrapping.
module apb_xfer_scheduler_rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index,
    output logic            any
);

    // Scan the requesters in priority order starting one past the previous winner.
    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int cand;
            cand = (int'(last) + k) % NREQ;
            if (!any && req[IW'(cand)]) begin
                grant[IW'(cand)] = 1'b1;
                index            = IW'(cand);
                any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_xfer_scheduler.sv
// Shares one APB master port between NREQ requesters: round-robin arbitration,
// SETUP/ACCESS sequencing, wait-state timeout and a one-cycle completion pulse.
module apb_xfer_scheduler
    import apb_xfer_scheduler_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int NSLV    = 4,
    parameter int SEL_LSB = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [32*NREQ-1:0]      req_addr,
    input  logic [NREQ-1:0]         req_write,
    input  logic [32*NREQ-1:0]      req_wdata,
    input  logic [4*NREQ-1:0]       req_strb,
    input  logic [3*NREQ-1:0]       req_prot,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [APB_DW-1:0]       rsp_rdata,
    output logic                    rsp_err,
    apb_xfer_scheduler_if.master    apb
);

    localparam int IW = $clog2(NREQ);
    localparam int SW = $clog2(NSLV);
    localparam int CW = $clog2(TIMEOUT) + 1;

    xfer_state_t       state;
    xfer_state_t       state_next;
    logic [IW-1:0]     last_q;
    logic [NREQ-1:0]   grant;
    logic [IW-1:0]     grant_idx;
    logic              grant_any;
    logic              accept;
    logic              xfer_end;
    logic              tmo_hit;
    logic [CW-1:0]     tmo_cnt;

    logic [APB_AW-1:0] sel_addr;
    logic              sel_write;
    logic [APB_DW-1:0] sel_wdata;
    logic [APB_SW-1:0] sel_strb;
    logic [2:0]        sel_prot;

    logic [IW-1:0]     id_q;
    logic [SW-1:0]     slv_q;
    logic [APB_AW-1:0] addr_q;
    logic              write_q;
    logic [APB_DW-1:0] wdata_q;
    logic [APB_SW-1:0] strb_q;
    logic [2:0]        prot_q;

    apb_xfer_scheduler_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .last  (last_q),
        .grant (grant),
        .index (grant_idx),
        .any   (grant_any)
    );

    // Route the winning requester's fields onto a single set of capture wires.
    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_prot  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr  = req_addr[32*i +: 32];
                sel_write = req_write[i];
                sel_wdata = req_wdata[32*i +: 32];
                sel_strb  = req_strb[4*i +: 4];
                sel_prot  = req_prot[3*i +: 3];
            end
        end
    end

    // State register; reset drops psel/penable at once since they decode from it.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next state plus the accept/complete strobes that the datapath keys off.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        xfer_end   = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    req_ready  = grant;
                    accept     = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (apb.pready) begin
                    xfer_end   = 1'b1;
                    state_next = ST_IDLE;
                end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                    xfer_end   = 1'b1;
                    tmo_hit    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the granted request; these registers hold the bus values between transfers.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            last_q  <= IW'(NREQ - 1);
            id_q    <= '0;
            slv_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
        end else if (accept) begin
            last_q  <= grant_idx;
            id_q    <= grant_idx;
            slv_q   <= sel_addr[SEL_LSB +: SW];
            addr_q  <= sel_addr;
            write_q <= sel_write;
            wdata_q <= sel_wdata;
            strb_q  <= sel_write ? sel_strb : '0;
            prot_q  <= sel_prot;
        end
    end

    // Count stalled ACCESS cycles so a dead slave cannot hang the port.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset)                                  tmo_cnt <= '0;
        else if (state == ST_SETUP)                   tmo_cnt <= '0;
        else if (state == ST_ACCESS && !apb.pready)   tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Completion pulse and response fields; fields persist until the next completion.
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= xfer_end;
            if (xfer_end) begin
                rsp_id    <= id_q;
                rsp_err   <= tmo_hit | apb.pslverr;
                rsp_rdata <= (!tmo_hit && !write_q) ? apb.prdata : '0;
            end
        end
    end

    assign apb.psel    = (state == ST_SETUP || state == ST_ACCESS) ? (NSLV'(1) << slv_q) : '0;
    assign apb.penable = (state == ST_ACCESS);
    assign apb.paddr   = addr_q;
    assign apb.pwrite  = write_q;
    assign apb.pwdata  = wdata_q;
    assign apb.pstrb   = strb_q;
    assign apb.pprot   = prot_q;

endmodule

// File: tb/tb_apb_xfer_scheduler.sv
// Self-checking bench for apb_xfer_scheduler: transfer-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_apb_xfer_scheduler;

    localparam int NREQ    = 2;
    localparam int NSLV    = 4;
    localparam int TIMEOUT = 16;

    logic              pclk;
    logic              preset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [32*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_write;
    logic [32*NREQ-1:0] req_wdata;
    logic [4*NREQ-1:0] req_strb;
    logic [3*NREQ-1:0] req_prot;
    logic              rsp_valid;
    logic              rsp_id;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    apb_xfer_scheduler_if #(.NSLV(NSLV)) apb ();

    apb_xfer_scheduler #(.NREQ(NREQ), .NSLV(NSLV), .SEL_LSB(8), .TIMEOUT(TIMEOUT)) dut (
        .pclk      (pclk),
        .preset    (preset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .req_prot  (req_prot),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .apb       (apb.master)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Free-running cycle index used for latency measurements.
    always @(posedge pclk) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- slave responder ----------------
    int          slv_waits = 0;
    logic        slv_err   = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    int          wcnt      = 0;

    // Answers ACCESS cycles after slv_waits stalls; negative slv_waits never answers.
    always @(posedge pclk) begin
        #1;
        if (apb.penable) begin
            apb.pready = (slv_waits >= 0 && wcnt >= slv_waits);
            wcnt++;
        end else begin
            apb.pready = 1'b0;
            wcnt       = 0;
        end
        apb.pslverr = apb.pready & slv_err;
        apb.prdata  = apb.pready ? slv_rdata : 32'h0;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          id;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } xfer_t;

    xfer_t       m_cur, m_nxt, m_bus;
    int          m_last;
    bit          m_busy;
    int          m_age;
    bit          m_rsp_due;
    int          m_rsp_id;
    logic [31:0] m_rsp_rdata;
    logic        m_rsp_err;

    // Per-cycle prediction: a transfer is accepted in an idle cycle, spends one cycle in
    // setup, then access cycles until ready or TIMEOUT stalls; the response follows.
    always @(negedge pclk) begin : model_cmp
        logic [NREQ-1:0] e_ready;
        logic [3:0]      e_psel;
        logic            e_pen;
        int              c;
        bit              found;
        bit              done;
        if (!preset) begin
            m_last    = NREQ - 1;
            m_busy    = 0;
            m_age     = 0;
            m_rsp_due = 0;
            m_bus     = '{0, 32'h0, 1'b0, 32'h0, 4'h0, 3'h0};
        end else begin
            e_ready = '0;
            e_psel  = 4'h0;
            e_pen   = 1'b0;
            found   = 0;
            done    = 0;
            if (!m_busy) begin
                for (int k = 1; k <= NREQ; k++) begin
                    c = (m_last + k) % NREQ;
                    if (!found && req_valid[c]) begin
                        found       = 1;
                        e_ready[c]  = 1'b1;
                        m_nxt.id    = c;
                        m_nxt.addr  = req_addr[32*c +: 32];
                        m_nxt.write = req_write[c];
                        m_nxt.wdata = req_wdata[32*c +: 32];
                        m_nxt.strb  = req_strb[4*c +: 4];
                        m_nxt.prot  = req_prot[3*c +: 3];
                    end
                end
            end else begin
                e_psel = 4'b0001 << m_cur.addr[9:8];
                e_pen  = (m_age >= 2);
            end
            check_output("req_ready", 32'(req_ready), 32'(e_ready));
            check_output("psel",      32'(apb.psel), 32'(e_psel));
            check_output("penable",   32'(apb.penable), 32'(e_pen));
            check_output("paddr",     apb.paddr, m_bus.addr);
            check_output("pwrite",    32'(apb.pwrite), 32'(m_bus.write));
            check_output("pwdata",    apb.pwdata, m_bus.wdata);
            check_output("pstrb",     32'(apb.pstrb), 32'(m_bus.write ? m_bus.strb : 4'h0));
            check_output("pprot",     32'(apb.pprot), 32'(m_bus.prot));
            check_output("rsp_valid", 32'(rsp_valid), 32'(m_rsp_due));
            if (m_rsp_due) begin
                check_output("rsp_id",    32'(rsp_id), 32'(m_rsp_id));
                check_output("rsp_rdata", rsp_rdata, m_rsp_rdata);
                check_output("rsp_err",   32'(rsp_err), 32'(m_rsp_err));
            end
            m_rsp_due = 0;
            if (found) begin
                m_cur  = m_nxt;
                m_bus  = m_nxt;
                m_busy = 1;
                m_age  = 1;
                m_last = m_nxt.id;
            end else if (m_busy) begin
                if (m_age >= 2 && apb.pready) begin
                    m_rsp_err   = apb.pslverr;
                    m_rsp_rdata = m_cur.write ? 32'h0 : apb.prdata;
                    done        = 1;
                end else if (m_age >= 2 && (m_age - 2) == TIMEOUT - 1) begin
                    m_rsp_err   = 1'b1;
                    m_rsp_rdata = 32'h0;
                    done        = 1;
                end
                if (done) begin
                    m_busy    = 0;
                    m_rsp_due = 1;
                    m_rsp_id  = m_cur.id;
                end else begin
                    m_age++;
                end
            end
        end
    end

    // ---------------- free-running observation counters ----------------
    int         n_pen = 0, n_psel = 0, n_rsp = 0, multi_ready = 0;
    logic [3:0] setup_psel = 4'h0;
    logic [3:0] seen_pstrb = 4'h0;
    int         grant_log[$];

    // Tallies bus activity so directed tests can compare against hand counts.
    always @(negedge pclk) begin
        if (apb.penable) n_pen++;
        if (apb.psel != 0) begin
            n_psel++;
            seen_pstrb = apb.pstrb;
            if (!apb.penable) setup_psel = apb.psel;
        end
        if (rsp_valid) n_rsp++;
        if (req_ready != 0) grant_log.push_back(req_ready[1] ? 1 : 0);
        if ($countones(req_ready) > 1) multi_ready++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply_stimulus(input int id, input logic [31:0] addr, input logic wr,
                                  input logic [31:0] wdata, input logic [3:0] strb,
                                  input logic [2:0] prot);
        req_addr[32*id +: 32]  = addr;
        req_write[id]          = wr;
        req_wdata[32*id +: 32] = wdata;
        req_strb[4*id +: 4]    = strb;
        req_prot[3*id +: 3]    = prot;
        req_valid[id]          = 1'b1;
    endtask

    task automatic wait_accept(input int id, output int acc);
        bit got;
        got = 0;
        acc = -1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge pclk);
            if (req_ready[id]) begin
                got = 1;
                acc = cyc;
            end
        end
        if (!got) bound_expired("accept");
        @(posedge pclk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int rc, output logic [31:0] rd, output logic id, output logic er);
        bit got;
        got = 0;
        rc  = -1;
        rd  = 32'h0;
        id  = 1'b0;
        er  = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge pclk);
            if (rsp_valid) begin
                got = 1;
                rc  = cyc;
                rd  = rsp_rdata;
                id  = rsp_id;
                er  = rsp_err;
            end
        end
        if (!got) bound_expired("response");
    endtask

    task automatic do_reset();
        @(posedge pclk);
        #1;
        preset = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        preset = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin : main
        int          acc, rc, base_pen, base_psel, base_rsp, base_log;
        logic [31:0] rd;
        logic        rid, rer;
        bit          got;

        preset    = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        repeat (3) @(posedge pclk);
        #1;
        preset = 1'b1;

        @(negedge pclk);
        check_output("reset_psel",      32'(apb.psel), 32'h0);
        check_output("reset_penable",   32'(apb.penable), 32'h0);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("reset_paddr",     apb.paddr, 32'h0);

        $display("[TB] single zero-wait write from req0");
        @(posedge pclk); #1;
        base_pen = n_pen;
        apply_stimulus(0, 32'h0000_0104, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b000);
        wait_accept(0, acc);
        wait_rsp(rc, rd, rid, rer);
        check_output("t1_latency",    32'(rc - acc), 32'd3);
        check_output("t1_setup_psel", 32'(setup_psel), 32'b0010);
        check_output("t1_pen_cycles", 32'(n_pen - base_pen), 32'd1);
        check_output("t1_rsp_err",    32'(rer), 32'h0);

        $display("[TB] read from req1 with two wait states");
        @(posedge pclk); #1;
        slv_waits = 2;
        slv_rdata = 32'hCAFE_BABE;
        base_psel = n_psel;
        apply_stimulus(1, 32'h0000_0308, 1'b0, 32'h1111_2222, 4'hF, 3'b010);
        wait_accept(1, acc);
        wait_rsp(rc, rd, rid, rer);
        check_output("t2_setup_psel",  32'(setup_psel), 32'b1000);
        check_output("t2_psel_cycles", 32'(n_psel - base_psel), 32'd4);
        check_output("t2_pstrb",       32'(seen_pstrb), 32'h0);
        check_output("t2_rsp_id",      32'(rid), 32'd1);
        check_output("t2_rsp_rdata",   rd, 32'hCAFE_BABE);
        check_output("t2_latency",     32'(rc - acc), 32'd5);

        $display("[TB] both requesters held from reset");
        do_reset();
        slv_waits = 0;
        base_log  = grant_log.size();
        apply_stimulus(0, 32'h0000_0010, 1'b1, 32'hA0A0_A0A0, 4'h3, 3'b001);
        apply_stimulus(1, 32'h0000_0114, 1'b0, 32'h0, 4'hF, 3'b100);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge pclk);
            #1;
            if (grant_log.size() - base_log >= 4) got = 1;
        end
        if (!got) bound_expired("rr_grants");
        @(posedge pclk); #1;
        req_valid = '0;
        wait_rsp(rc, rd, rid, rer);
        if (got) begin
            check_output("t3_grant0", 32'(grant_log[base_log + 0]), 32'd0);
            check_output("t3_grant1", 32'(grant_log[base_log + 1]), 32'd1);
            check_output("t3_grant2", 32'(grant_log[base_log + 2]), 32'd0);
            check_output("t3_grant3", 32'(grant_log[base_log + 3]), 32'd1);
        end
        check_output("t3_last_rsp_id", 32'(rid), 32'd1);
        check_output("t3_onehot_ready", 32'(multi_ready), 32'd0);

        $display("[TB] slave never ready, timeout abort");
        @(posedge pclk); #1;
        slv_waits = -1;
        base_pen  = n_pen;
        apply_stimulus(0, 32'h0000_0004, 1'b0, 32'h0, 4'hF, 3'b000);
        wait_accept(0, acc);
        wait_rsp(rc, rd, rid, rer);
        check_output("t4_pen_cycles", 32'(n_pen - base_pen), 32'd16);
        check_output("t4_rsp_err",    32'(rer), 32'h1);
        check_output("t4_rsp_rdata",  rd, 32'h0);
        check_output("t4_idle_psel",  32'(apb.psel), 32'h0);
        check_output("t4_idle_pen",   32'(apb.penable), 32'h0);
        slv_waits = 0;

        $display("[TB] slave error on write to slave 2");
        @(posedge pclk); #1;
        slv_err = 1'b1;
        apply_stimulus(1, 32'h0000_0200, 1'b1, 32'h0000_55AA, 4'b0011, 3'b010);
        wait_accept(1, acc);
        wait_rsp(rc, rd, rid, rer);
        check_output("t5_setup_psel", 32'(setup_psel), 32'b0100);
        check_output("t5_rsp_err",    32'(rer), 32'h1);
        check_output("t5_rsp_id",     32'(rid), 32'd1);
        slv_err = 1'b0;

        $display("[TB] reset during access phase");
        @(posedge pclk); #1;
        slv_waits = 3;
        apply_stimulus(0, 32'h0000_0100, 1'b1, 32'h7777_8888, 4'hF, 3'b000);
        wait_accept(0, acc);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge pclk);
            if (apb.penable) got = 1;
        end
        if (!got) bound_expired("t6_access");
        base_rsp = n_rsp;
        #2;
        preset = 1'b0;
        #1;
        check_output("t6_async_psel", 32'(apb.psel), 32'h0);
        check_output("t6_async_pen",  32'(apb.penable), 32'h0);
        repeat (2) @(posedge pclk);
        #1;
        preset = 1'b1;
        repeat (8) @(posedge pclk);
        check_output("t6_no_rsp", 32'(n_rsp - base_rsp), 32'd0);
        #1;
        slv_waits = 0;
        apply_stimulus(0, 32'h0000_0104, 1'b1, 32'h1234_5678, 4'hF, 3'b000);
        wait_accept(0, acc);
        wait_rsp(rc, rd, rid, rer);
        check_output("t6_rsp_id",     32'(rid), 32'd0);
        check_output("t6_rsp_err",    32'(rer), 32'h0);
        check_output("t6_setup_psel", 32'(setup_psel), 32'b0010);
        check_output("t6_latency",    32'(rc - acc), 32'd3);

        repeat (3) @(posedge pclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
